// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator hysteresis monitor.
package cmp_pkg;

  localparam int unsigned DB_W = 4;

  typedef enum logic [1:0] {
    BELOW   = 2'b00,
    ABOVE   = 2'b01,
    FALLING = 2'b10
  } state_t;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  function automatic logic is_onehot3(input logic [2:0] flags);
    return (flags == GT) || (flags == EQ) || (flags == LT);
  endfunction

endpackage

// File: rtl/cmp_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module cmp_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cmp_hysteresis_monitor.sv
// Debounce + hysteresis on one-hot comparator flags, producing a stable alarm,
// rise/fall pulses, a saturating rise-event count and a sticky flag-integrity error.
module cmp_hysteresis_monitor
  import cmp_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             gt,
  input  logic             eq,
  input  logic             lt,
  input  logic             clr_count,
  output logic             alarm,
  output logic             alarm_rise,
  output logic             alarm_fall,
  output logic [CNT_W-1:0] event_count,
  output logic             err
);

  localparam logic [DB_W-1:0] DB_LIM = DB_W'(DEBOUNCE);

  state_t          state, state_nxt;
  logic [DB_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [2:0]      flags;
  logic            legal, bad;
  logic            rise_nxt, fall_nxt, alarm_nxt;

  assign flags   = {gt, eq, lt};
  assign legal   = valid_in & is_onehot3(flags);
  assign bad     = valid_in & ~is_onehot3(flags);
  assign cnt_inc = cnt + DB_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BELOW;
      cnt        <= '0;
      alarm      <= 1'b0;
      alarm_rise <= 1'b0;
      alarm_fall <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      alarm      <= alarm_nxt;
      alarm_rise <= rise_nxt;
      alarm_fall <= fall_nxt;
      err        <= err | bad;
    end
  end

  // BELOW with cnt>0 is the rising phase; eq clears progress in either direction.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      BELOW: begin
        if (legal) begin
          if (flags == GT) begin
            if (cnt_inc >= DB_LIM) begin
              state_nxt = ABOVE;
              cnt_nxt   = '0;
              rise_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
      end
      ABOVE: begin
        if (legal && (flags == LT)) begin
          if (DB_LIM == DB_W'(1)) begin
            state_nxt = BELOW;
            cnt_nxt   = '0;
            fall_nxt  = 1'b1;
          end else begin
            state_nxt = FALLING;
            cnt_nxt   = DB_W'(1);
          end
        end
      end
      FALLING: begin
        if (legal) begin
          if (flags == LT) begin
            if (cnt_inc >= DB_LIM) begin
              state_nxt = BELOW;
              cnt_nxt   = '0;
              fall_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            state_nxt = ABOVE;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = BELOW;
        cnt_nxt   = '0;
      end
    endcase
    alarm_nxt = (state_nxt == ABOVE) || (state_nxt == FALLING);
  end

  cmp_sat_counter #(
    .W(CNT_W)
  ) u_event_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_count),
    .inc  (rise_nxt),
    .count(event_count)
  );

endmodule
